// File: rtl/uio_prbs_pkg.sv
// Shared definitions for the UIO PRBS-31 (x^31 + x^28 + 1) checker and generator.
// Provides the hunt/lock state type, the tap constants and the 128-bit word predictor.
package uio_prbs_pkg;

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } prbs_state_e;

  localparam int unsigned PRBS_TAP_A = 31;
  localparam int unsigned PRBS_TAP_B = 28;
  localparam int unsigned UIO_W      = 128;

  // st holds seq(-31)..seq(-1) with st[30] newest; result bit i is seq(i).
  function automatic logic [UIO_W-1:0] prbs31_adv128(input logic [PRBS_TAP_A-1:0] st);
    logic [PRBS_TAP_A+UIO_W-1:0] seq;
    seq = '0;
    seq[PRBS_TAP_A-1:0] = st;
    for (int unsigned i = 0; i < UIO_W; i++) begin
      seq[PRBS_TAP_A+i] = seq[i] ^ seq[i+PRBS_TAP_A-PRBS_TAP_B];
    end
    return seq[PRBS_TAP_A +: UIO_W];
  endfunction

endpackage

// File: rtl/uio_prbs_checker_popcnt.sv
// Registered 128-bit popcount, one cycle of latency; shared with the request-side
// PRBS generator self-test.
module uio_popcnt128 (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] i_vec,
  output logic [7:0]   o_cnt
);

  logic [7:0] w_cnt;
  logic [7:0] r_cnt;

  always_comb begin
    w_cnt = '0;
    for (int unsigned i = 0; i < 128; i++) begin
      w_cnt = w_cnt + 8'(i_vec[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/uio_prbs_checker.sv
// Receive-side PRBS-31 checker on the 128-bit UIO response stream: hunts for the
// pattern, locks, then counts word/bit errors with a free-running prediction.
module uio_prbs_checker
  import uio_prbs_pkg::*;
#(
  parameter int unsigned LOCK_WORDS   = 4,
  parameter int unsigned UNLOCK_WORDS = 8,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_enable,
  input  logic                 i_clear,
  input  logic                 uio_rs_vld,
  input  logic [127:0]         uio_rs_data,
  output logic                 o_locked,
  output logic [CNT_WIDTH-1:0] o_word_cnt,
  output logic [CNT_WIDTH-1:0] o_err_word_cnt,
  output logic [CNT_WIDTH-1:0] o_bit_err_cnt,
  output logic [7:0]           o_lock_loss_cnt
);

  localparam int unsigned MW  = $clog2(LOCK_WORDS + 1);
  localparam int unsigned MSW = $clog2(UNLOCK_WORDS + 1);
  localparam int unsigned SW  = CNT_WIDTH + 9;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  prbs_state_e          r_state, w_state_nxt;
  logic [30:0]          r_st, w_st_nxt;
  logic                 r_have_seed, w_have_seed_nxt;
  logic [MW-1:0]        r_match_cnt, w_match_nxt, w_match_inc;
  logic [MSW-1:0]       r_miss_cnt, w_miss_nxt, w_miss_inc;

  logic [127:0]         w_exp, w_diff;
  logic [30:0]          w_seed;
  logic                 w_match, w_seed_ok, w_accept, w_err_hit, w_lock_loss;

  logic                 r_pc_vld;
  logic [7:0]           w_pc;
  logic [SW-1:0]        w_bit_sum;
  logic [CNT_WIDTH-1:0] w_bit_add;

  logic [CNT_WIDTH-1:0] r_word_cnt, r_err_word_cnt, r_bit_err_cnt;
  logic [7:0]           r_lock_loss_cnt;

  assign w_exp     = prbs31_adv128(r_st);
  assign w_diff    = uio_rs_data ^ w_exp;
  assign w_match   = ~|w_diff;
  assign w_seed    = uio_rs_data[127:97];
  assign w_seed_ok = |w_seed;
  assign w_accept  = i_enable & uio_rs_vld;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_HUNT;
      r_st        <= '0;
      r_have_seed <= 1'b0;
      r_match_cnt <= '0;
      r_miss_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_st        <= w_st_nxt;
      r_have_seed <= w_have_seed_nxt;
      r_match_cnt <= w_match_nxt;
      r_miss_cnt  <= w_miss_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_st_nxt        = r_st;
    w_have_seed_nxt = r_have_seed;
    w_match_nxt     = r_match_cnt;
    w_miss_nxt      = r_miss_cnt;
    w_match_inc     = '0;
    w_miss_inc      = r_miss_cnt + MSW'(1);
    w_err_hit       = 1'b0;
    w_lock_loss     = 1'b0;
    if (!i_enable) begin
      w_state_nxt     = ST_HUNT;
      w_have_seed_nxt = 1'b0;
      w_match_nxt     = '0;
      w_miss_nxt      = '0;
    end else if (uio_rs_vld) begin
      case (r_state)
        ST_HUNT: begin
          // A zero seed can never lock, so its match run is discarded.
          if (r_have_seed && w_match && w_seed_ok) begin
            w_match_inc = r_match_cnt + MW'(1);
          end
          w_st_nxt        = w_seed;
          w_have_seed_nxt = w_seed_ok;
          w_match_nxt     = w_match_inc;
          if (w_match_inc == MW'(LOCK_WORDS)) begin
            w_state_nxt = ST_LOCKED;
            w_miss_nxt  = '0;
          end
        end
        ST_LOCKED: begin
          w_st_nxt = w_exp[127:97];
          if (w_match) begin
            w_miss_nxt = '0;
          end else begin
            w_err_hit  = 1'b1;
            w_miss_nxt = w_miss_inc;
            if (w_miss_inc == MSW'(UNLOCK_WORDS)) begin
              w_state_nxt     = ST_HUNT;
              w_match_nxt     = '0;
              w_st_nxt        = w_seed;
              w_have_seed_nxt = w_seed_ok;
              w_lock_loss     = 1'b1;
            end
          end
        end
        default: w_state_nxt = ST_HUNT;
      endcase
    end
  end

  uio_popcnt128 u_popcnt (
    .clk   (clk),
    .reset (reset),
    .i_vec (w_diff),
    .o_cnt (w_pc)
  );

  assign w_bit_sum = SW'(r_bit_err_cnt) + SW'(w_pc);
  assign w_bit_add = (w_bit_sum > SW'(CNT_MAX)) ? CNT_MAX : w_bit_sum[CNT_WIDTH-1:0];

  // r_pc_vld tags the popcount in flight; a clear kills it so it is never added.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc_vld        <= 1'b0;
      r_word_cnt      <= '0;
      r_err_word_cnt  <= '0;
      r_bit_err_cnt   <= '0;
      r_lock_loss_cnt <= '0;
    end else begin
      r_pc_vld <= w_err_hit & ~i_clear;
      if (i_clear) begin
        r_word_cnt      <= '0;
        r_err_word_cnt  <= '0;
        r_bit_err_cnt   <= '0;
        r_lock_loss_cnt <= '0;
      end else begin
        if (w_accept && (r_word_cnt != CNT_MAX)) begin
          r_word_cnt <= r_word_cnt + CNT_WIDTH'(1);
        end
        if (w_err_hit && (r_err_word_cnt != CNT_MAX)) begin
          r_err_word_cnt <= r_err_word_cnt + CNT_WIDTH'(1);
        end
        if (w_lock_loss && (r_lock_loss_cnt != 8'hFF)) begin
          r_lock_loss_cnt <= r_lock_loss_cnt + 8'd1;
        end
        if (r_pc_vld) begin
          r_bit_err_cnt <= w_bit_add;
        end
      end
    end
  end

  assign o_locked        = (r_state == ST_LOCKED);
  assign o_word_cnt      = r_word_cnt;
  assign o_err_word_cnt  = r_err_word_cnt;
  assign o_bit_err_cnt   = r_bit_err_cnt;
  assign o_lock_loss_cnt = r_lock_loss_cnt;

endmodule

// File: tb/tb_uio_prbs_checker.sv
// Scoreboard bench for uio_prbs_checker: a 32-bit and a 4-bit counter instance share
// one stimulus stream; a bit-serial reference model predicts every cycle's outputs.
module tb_uio_prbs_checker;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         i_enable = 1'b0;
  logic         i_clear = 1'b0;
  logic         uio_rs_vld = 1'b0;
  logic [127:0] uio_rs_data = '0;

  logic         b_locked, s_locked;
  logic [31:0]  b_word, b_errw, b_bit;
  logic [3:0]   s_word, s_errw, s_bit;
  logic [7:0]   b_loss, s_loss;

  always #5 clk = ~clk;

  uio_prbs_checker #(.LOCK_WORDS(4), .UNLOCK_WORDS(8), .CNT_WIDTH(32)) u_dut (
    .clk(clk), .reset(reset), .i_enable(i_enable), .i_clear(i_clear),
    .uio_rs_vld(uio_rs_vld), .uio_rs_data(uio_rs_data),
    .o_locked(b_locked), .o_word_cnt(b_word), .o_err_word_cnt(b_errw),
    .o_bit_err_cnt(b_bit), .o_lock_loss_cnt(b_loss)
  );

  uio_prbs_checker #(.LOCK_WORDS(4), .UNLOCK_WORDS(8), .CNT_WIDTH(4)) u_dut_sat (
    .clk(clk), .reset(reset), .i_enable(i_enable), .i_clear(i_clear),
    .uio_rs_vld(uio_rs_vld), .uio_rs_data(uio_rs_data),
    .o_locked(s_locked), .o_word_cnt(s_word), .o_err_word_cnt(s_errw),
    .o_bit_err_cnt(s_bit), .o_lock_loss_cnt(s_loss)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int     cyc;
    bit     locked;
    longint word, errw, loss, bits;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // reference model state
  bit          m_locked, m_have;
  int          m_match, m_miss;
  logic [30:0] m_st;
  longint      m_word, m_errw, m_loss, m_bit, m_pend;
  logic [30:0] gen_st;
  bit          seen_locked;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] sat(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  // Bit-serial LFSR: window[0] = seq(n-31), window[3] = seq(n-28).
  function automatic logic [127:0] ref_word(input logic [30:0] st);
    logic [30:0]  w;
    logic [127:0] r;
    logic         b;
    w = st;
    r = '0;
    for (int i = 0; i < 128; i++) begin
      b    = w[0] ^ w[3];
      r[i] = b;
      w    = {b, w[30:1]};
    end
    return r;
  endfunction

  function automatic logic [127:0] rand_mask(input int n);
    logic [127:0] m;
    m = '0;
    while ($countones(m) < n) m[$urandom_range(0, 127)] = 1'b1;
    return m;
  endfunction

  function automatic logic [127:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    m_locked = 0; m_have = 0; m_match = 0; m_miss = 0; m_st = '0;
    m_word = 0; m_errw = 0; m_loss = 0; m_bit = 0; m_pend = 0;
  endtask

  task automatic model_step(input bit vld, input bit en, input bit clr, input logic [127:0] data);
    logic [127:0] e, d;
    logic [30:0]  seed;
    bit           ok, err, lost;
    int           pc;
    err = 0; lost = 0; pc = 0;
    if (!en) begin
      m_locked = 0; m_have = 0; m_match = 0; m_miss = 0;
    end else if (vld) begin
      e    = ref_word(m_st);
      d    = data ^ e;
      ok   = (d == '0);
      seed = data[127:97];
      if (!m_locked) begin
        m_match = (m_have && ok) ? m_match + 1 : 0;
        if (seed == '0) m_match = 0;
        m_have = (seed != '0);
        m_st   = seed;
        if (m_match == 4) begin
          m_locked = 1;
          m_miss   = 0;
        end
      end else begin
        m_st = e[127:97];
        if (ok) m_miss = 0;
        else begin
          err  = 1;
          pc   = $countones(d);
          m_miss++;
          if (m_miss == 8) begin
            m_locked = 0; m_match = 0; m_st = seed; m_have = (seed != '0); lost = 1;
          end
        end
      end
    end
    if (clr) begin
      m_word = 0; m_errw = 0; m_loss = 0; m_bit = 0; m_pend = 0;
    end else begin
      m_word += (vld && en) ? 1 : 0;
      m_errw += err ? 1 : 0;
      m_loss += lost ? 1 : 0;
      m_bit  += m_pend;
      m_pend  = err ? pc : 0;
    end
  endtask

  task automatic step(input bit vld, input bit en, input bit clr, input logic [127:0] data);
    exp_t e;
    @(posedge clk);
    #1;
    seen_locked = b_locked;
    uio_rs_vld  = vld;
    i_enable    = en;
    i_clear     = clr;
    uio_rs_data = data;
    model_step(vld, en, clr, data);
    e.cyc = cyc + 1;
    e.locked = m_locked;
    e.word = m_word; e.errw = m_errw; e.loss = m_loss; e.bits = m_bit;
    sb.push_back(e);
  endtask

  task automatic next_clean(output logic [127:0] w);
    w      = ref_word(gen_st);
    gen_st = w[127:97];
  endtask

  task automatic send_clean();
    logic [127:0] w;
    next_clean(w);
    step(1, 1, 0, w);
  endtask

  task automatic send_err(input int nbits);
    logic [127:0] w;
    next_clean(w);
    step(1, 1, 0, w ^ rand_mask(nbits));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, '0);
  endtask

  task automatic clear_cnt();
    step(0, 1, 1, '0);
  endtask

  task automatic wait_lock(input int max_words, input string name);
    for (int i = 0; i < max_words; i++) begin
      if (b_locked === 1'b1) break;
      send_clean();
    end
    idle(1);
    check(name, b_locked, 1);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_locked"}, b_locked, 0);
    check({tag, "_word"}, b_word, 0);
    check({tag, "_errw"}, b_errw, 0);
    check({tag, "_bit"}, b_bit, 0);
    check({tag, "_loss"}, b_loss, 0);
    check({tag, "_s_locked"}, s_locked, 0);
    check({tag, "_s_word"}, s_word, 0);
    check({tag, "_s_errw"}, s_errw, 0);
    check({tag, "_s_bit"}, s_bit, 0);
    check({tag, "_s_loss"}, s_loss, 0);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      if (mon_e.cyc != cyc) begin
        check("sb_stale_entry", mon_e.cyc, cyc);
      end else begin
        check("locked", b_locked, mon_e.locked);
        check("word_cnt", b_word, sat(mon_e.word, 32));
        check("err_word_cnt", b_errw, sat(mon_e.errw, 32));
        check("bit_err_cnt", b_bit, sat(mon_e.bits, 32));
        check("lock_loss_cnt", b_loss, sat(mon_e.loss, 8));
        check("s_locked", s_locked, mon_e.locked);
        check("s_word_cnt", s_word, sat(mon_e.word, 4));
        check("s_err_word_cnt", s_errw, sat(mon_e.errw, 4));
        check("s_bit_err_cnt", s_bit, sat(mon_e.bits, 4));
        check("s_lock_loss_cnt", s_loss, sat(mon_e.loss, 8));
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] w;
    bit           never_locked;
    bit           vld, en, clr;
    int           burst, r;

    model_reset();
    gen_st = 31'h7FFF_FFFF;
    #2;
    check_zero_outputs("reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // clean lock from seed 7FFFFFFF
    for (int k = 1; k <= 20; k++) begin
      send_clean();
      if (k == 5) check("lock_before_word5", seen_locked, 0);
      if (k == 6) check("lock_after_word5", seen_locked, 1);
    end
    idle(2);
    check("clean_word_cnt", b_word, 20);
    check("clean_err_word_cnt", b_errw, 0);
    check("clean_bit_err_cnt", b_bit, 0);

    // single-bit error on word 10
    clear_cnt();
    for (int k = 1; k <= 9; k++) send_clean();
    next_clean(w);
    w[5] = ~w[5];
    step(1, 1, 0, w);
    send_clean();
    idle(2);
    check("single_err_word_cnt", b_errw, 1);
    check("single_bit_err_cnt", b_bit, 1);
    check("single_still_locked", b_locked, 1);

    // loss of lock: 8 words with 3 flipped bits
    clear_cnt();
    for (int k = 0; k < 8; k++) send_err(3);
    idle(2);
    check("loss_err_word_cnt", b_errw, 8);
    check("loss_bit_err_cnt", b_bit, 24);
    check("loss_lock_loss_cnt", b_loss, 1);
    check("loss_unlocked", b_locked, 0);
    wait_lock(8, "relock_after_loss");

    // degenerate all-zero stream, starting from HUNT
    step(0, 0, 1, '0);
    never_locked = 1'b0;
    for (int k = 0; k < 50; k++) begin
      step(1, 1, 0, '0);
      never_locked |= seen_locked;
    end
    idle(2);
    never_locked |= b_locked;
    check("zero_never_locked", never_locked, 0);
    check("zero_word_cnt", b_word, 50);
    wait_lock(10, "relock_after_zero");

    // saturation: 20 locked error words with 2 bit errors each
    clear_cnt();
    for (int k = 0; k < 20; k++) begin
      send_err(2);
      send_clean();
    end
    idle(2);
    check("sat_s_err_word_cnt", s_errw, 15);
    check("sat_s_bit_err_cnt", s_bit, 15);
    check("sat_err_word_cnt", b_errw, 20);
    check("sat_bit_err_cnt", b_bit, 40);

    // clear coinciding with an error word, another popcount already in flight
    send_err(2);
    next_clean(w);
    step(1, 1, 1, w ^ rand_mask(2));
    idle(2);
    check("clr_word_cnt", b_word, 0);
    check("clr_err_word_cnt", b_errw, 0);
    check("clr_bit_err_cnt", b_bit, 0);
    check("clr_lock_loss_cnt", b_loss, 0);
    check("clr_s_bit_err_cnt", s_bit, 0);

    // randomized traffic
    burst = 0;
    for (int k = 0; k < 600; k++) begin
      vld = ($urandom_range(0, 9) < 8);
      en  = ($urandom_range(0, 59) != 0);
      clr = ($urandom_range(0, 99) < 2);
      if (burst == 0 && $urandom_range(0, 149) == 0) burst = $urandom_range(6, 12);
      if (vld) begin
        next_clean(w);
        if (burst > 0) begin
          w = w ^ rand_mask($urandom_range(1, 5));
          burst--;
        end else begin
          r = $urandom_range(0, 99);
          if (r < 6) w = w ^ rand_mask($urandom_range(1, 4));
          else if (r < 8) w = rand_word();
        end
      end else begin
        w = rand_word();
      end
      step(vld, en, clr, w);
    end
    idle(2);

    // mid-stream asynchronous reset
    for (int k = 0; k < 6; k++) send_err(1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    uio_rs_vld = 1'b0;
    i_clear = 1'b0;
    sb.delete();
    model_reset();
    #1;
    check_zero_outputs("midrst");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    wait_lock(10, "relock_after_reset");
    idle(2);

    @(posedge clk);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
